ysyx_22040759_lsu_ctrl: RTL and testbench
=========================================

// Module: ysyx_22040759_lsu_ctrl
// PURPOSE
//  Load/store sequencer between decode/ALU stage and the data-memory bus.
//  Takes mem_ren/mem_wen/func3 from decode and the ALU address, runs one
//  valid/ready bus transaction per memory instruction, and stalls PC/regfile
//  until done. Generates byte masks and lane shifts, sign/zero-extends loads,
//  and flags misaligned, illegal-size and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYC  256  cycles in REQ+RSP before aborting with err
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  ex_valid    in   1   current instruction valid
//  mem_ren     in   1   decode: load
//  mem_wen     in   1   decode: store
//  func3       in   3   decode: size/sign (000 b,001 h,010 w,011 d,100 bu,101 hu,110 wu)
//  addr        in   64  effective address (ALU result)
//  wdata       in   64  store data (rs2)
//  stall       out  1   hold PC, suppress regfile write
//  ld_valid    out  1   1-cycle pulse: ld_data valid, write rd
//  ld_data     out  64  extended load result
//  err         out  1   1-cycle pulse: misaligned/illegal/timeout
//  req_valid   out  1   bus request valid
//  req_ready   in   1   bus accepts request
//  req_addr    out  64  {addr[63:3],3'b0}
//  req_wen     out  1   1 store, 0 load
//  req_wdata   out  64  wdata << 8*addr[2:0]
//  req_wmask   out  8   byte enables; 0 for loads
//  rsp_valid   in   1   read data / write ack
//  rsp_rdata   in   64  read data, 8-byte aligned word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, ld_data 0, timeout counter 0. Async
//   assert mid-transaction abandons it; req_valid/stall drop immediately.
//  start = ex_valid & (mem_ren|mem_wen) in IDLE.
//  bad = misaligned (h:addr[0]; w/wu:addr[1:0]!=0; d:addr[2:0]!=0) |
//   func3==111 | (ren&wen) | (wen & func3[2]).
//  FSM IDLE->REQ->RSP->DONE->IDLE:
//   IDLE: start&!bad: latch addr/func3/wen/shifted wdata/mask, stall=1, ->REQ.
//    start&bad: err=1 one cycle, stall=0, no bus traffic, stay IDLE.
//   REQ: req_valid=1, payload stable until req_ready; handshake ->RSP.
//   RSP: wait rsp_valid (earliest the cycle after handshake); latch rdata ->DONE.
//   DONE: stall=0; loads ld_valid=1; ex_valid ignored (same instr); ->IDLE.
//  stall = (IDLE&start&!bad) | REQ | RSP.
//  Zero-wait bus: 4 cycles IDLE..DONE, stall high 3.
//  Mask: b 8'h01, h 8'h03, w 8'h0F, d 8'hFF, shifted left by addr[2:0].
//  Load: rsp_rdata >> 8*addr[2:0], then sign-extend (b/h/w) or zero-extend
//   (bu/hu/wu); d passes through.
//  Timeout: counter clears entering REQ, counts in REQ/RSP; at TIMEOUT_CYC
//   ->DONE with err=1, ld_valid=0, ld_data=0; req_valid dropped.
//  rsp_valid outside RSP ignored; req_ready outside REQ ignored.
// TESTING
//  lbu @0x80000003, rdata 0x1122334455667788 -> req_addr 0x80000000, ld_data 0x55, ld_valid 1 cyc
//  lb @0x80000000, rdata 0x..85 -> ld_data 0xFFFFFFFFFFFFFF85; lwu of 0x80000000 -> 0x0000000080000000
//  sw @0x80000004 wdata 0xDEADBEEF -> req_wen 1, wmask 0xF0, wdata 0xDEADBEEF00000000
//  req_ready low 5 cycles -> req_valid/addr/wdata/wmask stable, stall high throughout
//  ld @0x80000004 -> err 1 cycle, req_valid never 1, stall 0; TIMEOUT_CYC=16, no rsp -> err at cycle 16, ld_valid 0
//  rst_n low in RSP -> req_valid,stall 0 same cycle; after release IDLE, next lw completes normally

Source files
------------

// File: rtl/ysyx_22040759_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_lsu_ctrl
// Load/store sequencer between the decode/ALU stage and the data-memory bus.
// Each memory instruction runs one valid/ready bus transaction. The PC and
// regfile are stalled until the transaction completes. The block generates
// byte masks and lane-shifted store data, and sign/zero-extends load data.
// Misaligned accesses, illegal sizes and bus timeouts raise a one-cycle error.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_ex_valid              current instruction valid
//   i_mem_ren, i_mem_wen    decode: load / store
//   i_func3                 size/sign (b,h,w,d,bu,hu,wu)
//   i_addr, i_wdata         effective address, store data
//   o_stall                 hold PC, suppress regfile write
//   o_ld_valid, o_ld_data   one-cycle load result pulse, extended data
//   o_err                   one-cycle misaligned/illegal/timeout pulse
//   o_req_*, i_req_ready    bus request channel
//   i_rsp_valid, i_rsp_rdata bus response channel (8-byte aligned word)
// ----------------------------------------------------------------------------
module ysyx_22040759_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_valid,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [2:0]  i_func3,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic        o_stall,
    output logic        o_ld_valid,
    output logic [63:0] o_ld_data,
    output logic        o_err,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [63:0] o_req_addr,
    output logic        o_req_wen,
    output logic [63:0] o_req_wdata,
    output logic [7:0]  o_req_wmask,
    input  logic        i_rsp_valid,
    input  logic [63:0] i_rsp_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [63:0]   r_addr;
    logic [2:0]    r_func3;
    logic          r_wen;
    logic [63:0]   r_wdata;
    logic [7:0]    r_wmask;
    logic [CW-1:0] r_cnt;
    logic          r_to;
    logic [63:0]   r_ld_data;

    logic          w_start;
    logic          w_misal;
    logic          w_bad;
    logic          w_go;
    logic          w_busy;
    logic          w_timeout;
    logic [7:0]    w_mask;
    logic [63:0]   w_rsh;
    logic [63:0]   w_ld_ext;

    // Reset gates start so that a held ex_valid cannot raise stall/err while
    // the block is in reset.
    assign w_start = i_rst_n & i_ex_valid & (i_mem_ren | i_mem_wen) & (r_state == S_IDLE);

    always_comb begin
        w_misal = 1'b0;
        case (i_func3)
            3'b001, 3'b101: w_misal = i_addr[0];
            3'b010, 3'b110: w_misal = (i_addr[1:0] != 2'b00);
            3'b011:         w_misal = (i_addr[2:0] != 3'b000);
            default:        w_misal = 1'b0;
        endcase
    end

    assign w_bad = w_misal | (i_func3 == 3'b111) | (i_mem_ren & i_mem_wen)
                 | (i_mem_wen & i_func3[2]);
    assign w_go  = w_start & ~w_bad;

    always_comb begin
        w_mask = '0;
        case (i_func3[1:0])
            2'b00:   w_mask = 8'h01;
            2'b01:   w_mask = 8'h03;
            2'b10:   w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
        w_mask = w_mask << i_addr[2:0];
    end

    assign w_busy    = (r_state == S_REQ) | (r_state == S_RSP);
    assign w_timeout = w_busy & (r_cnt == CW'(TIMEOUT_CYC - 1));

    // Bring the addressed lane down to bit 0 before extension.
    assign w_rsh = i_rsp_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_ld_ext = w_rsh;
        case (r_func3)
            3'b000:  w_ld_ext = {{56{w_rsh[7]}},  w_rsh[7:0]};
            3'b001:  w_ld_ext = {{48{w_rsh[15]}}, w_rsh[15:0]};
            3'b010:  w_ld_ext = {{32{w_rsh[31]}}, w_rsh[31:0]};
            3'b100:  w_ld_ext = {56'd0, w_rsh[7:0]};
            3'b101:  w_ld_ext = {48'd0, w_rsh[15:0]};
            3'b110:  w_ld_ext = {32'd0, w_rsh[31:0]};
            default: w_ld_ext = w_rsh;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_REQ;
            S_REQ: begin
                if (w_timeout)        w_next = S_DONE;
                else if (i_req_ready) w_next = S_RSP;
            end
            S_RSP: begin
                if (w_timeout)        w_next = S_DONE;
                else if (i_rsp_valid) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_func3   <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_cnt     <= '0;
            r_to      <= 1'b0;
            r_ld_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_addr  <= i_addr;
                r_func3 <= i_func3;
                r_wen   <= i_mem_wen;
                r_wdata <= i_mem_wen ? (i_wdata << {i_addr[2:0], 3'b000}) : '0;
                r_wmask <= i_mem_wen ? w_mask : '0;
                r_cnt   <= '0;
                r_to    <= 1'b0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_timeout) begin
                    r_to      <= 1'b1;
                    r_ld_data <= '0;
                end else if ((r_state == S_RSP) && i_rsp_valid && !r_wen) begin
                    r_ld_data <= w_ld_ext;
                end
            end
        end
    end

    assign o_stall     = w_go | w_busy;
    assign o_err       = (w_start & w_bad) | ((r_state == S_DONE) & r_to);
    assign o_ld_valid  = (r_state == S_DONE) & ~r_wen & ~r_to;
    assign o_ld_data   = r_ld_data;
    assign o_req_valid = (r_state == S_REQ);
    assign o_req_addr  = {r_addr[63:3], 3'b000};
    assign o_req_wen   = r_wen;
    assign o_req_wdata = r_wdata;
    assign o_req_wmask = r_wmask;

endmodule

// File: tb/tb_ysyx_22040759_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_22040759_lsu_ctrl: directed load/store/error/timeout/
// reset sequence. Expected load results and error pulses go into a queue at
// issue time and are checked when the DUT pulses ld_valid or err.
// ----------------------------------------------------------------------------
module tb_ysyx_22040759_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_ren, mem_wen;
    logic [2:0]  func3;
    logic [63:0] addr, wdata;
    logic        stall, ld_valid, err;
    logic [63:0] ld_data;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [63:0] data;
    } ev_t;
    ev_t sbq[$];

    ysyx_22040759_lsu_ctrl #(.TIMEOUT_CYC(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ex_valid (ex_valid),
        .i_mem_ren  (mem_ren),
        .i_mem_wen  (mem_wen),
        .i_func3    (func3),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_stall    (stall),
        .o_ld_valid (ld_valid),
        .o_ld_data  (ld_data),
        .o_err      (err),
        .o_req_valid(req_valid),
        .i_req_ready(req_ready),
        .o_req_addr (req_addr),
        .o_req_wen  (req_wen),
        .o_req_wdata(req_wdata),
        .o_req_wmask(req_wmask),
        .i_rsp_valid(rsp_valid),
        .i_rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ld_valid/err pulse must match the oldest
    // pending expectation.
    always @(negedge clk) begin
        if (rst_n && (ld_valid || err)) begin
            check("sb_pending", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                ev_t ev;
                ev = sbq.pop_front();
                check("sb_err", err, ev.is_err);
                check("sb_ld_valid", ld_valid, !ev.is_err);
                if (ev.chk_data) check("sb_ld_data", ld_data, ev.data);
            end
        end
    end

    task automatic push_ev(input bit is_err, input bit chk, input logic [63:0] d);
        ev_t ev;
        ev.is_err   = is_err;
        ev.chk_data = chk;
        ev.data     = d;
        sbq.push_back(ev);
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
    endtask

    // One good transaction. Request-phase inputs are scrambled after the start
    // cycle so payload stability proves the DUT latched them.
    task automatic txn(input bit ren, input bit wen, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       input logic [63:0] exp_ld, input logic [7:0] exp_mask,
                       input logic [63:0] exp_wd, input int unsigned rdy_dly,
                       input int unsigned rsp_dly, input bit junk_rsp);
        if (ren) push_ev(1'b0, 1'b1, exp_ld);
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_ren = ren; mem_wen = wen; func3 = f3; addr = a; wdata = wd;
        req_ready = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        check("start_stall", stall, 1'b1);
        check("start_err", err, 1'b0);
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; addr = ~a; wdata = ~wd;
        rsp_valid = junk_rsp; rsp_rdata = ~rd;
        for (int i = 0; i <= int'(rdy_dly); i++) begin
            req_ready = (i == int'(rdy_dly));
            @(negedge clk);
            check("req_valid", req_valid, 1'b1);
            check("req_stall", stall, 1'b1);
            check("req_addr", req_addr, {a[63:3], 3'b000});
            check("req_wen", req_wen, wen);
            check("req_wmask", req_wmask, exp_mask);
            if (wen) check("req_wdata", req_wdata, exp_wd);
            @(posedge clk); #1;
        end
        req_ready = 1'b0;
        for (int i = 0; i <= int'(rsp_dly); i++) begin
            rsp_valid = (i == int'(rsp_dly));
            rsp_rdata = (i == int'(rsp_dly)) ? rd : ~rd;
            @(negedge clk);
            check("rsp_req_valid", req_valid, 1'b0);
            check("rsp_stall", stall, 1'b1);
            @(posedge clk); #1;
        end
        rsp_valid = 1'b0;
        @(negedge clk);
        check("done_stall", stall, 1'b0);
        check("done_req_valid", req_valid, 1'b0);
    endtask

    task automatic bad_req(input bit ren, input bit wen, input logic [2:0] f3, input logic [63:0] a);
        push_ev(1'b1, 1'b0, '0);
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_ren = ren; mem_wen = wen; func3 = f3; addr = a; wdata = '1;
        @(negedge clk);
        check("bad_stall", stall, 1'b0);
        check("bad_req_valid", req_valid, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("bad_after_req_valid", req_valid, 1'b0);
        check("bad_after_stall", stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        func3 = '0; addr = '0; wdata = '0; rsp_rdata = '0;
        #3;
        check("rst_stall", stall, 1'b0);
        check("rst_ld_valid", ld_valid, 1'b0);
        check("rst_ld_data", ld_data, 64'd0);
        check("rst_err", err, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_req_wmask", req_wmask, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // stray handshakes in IDLE are ignored
        @(posedge clk); #1;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("idle_stray_stall", stall, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("idle_stray_req_valid", req_valid, 1'b0);

        // loads
        txn(1, 0, 3'b100, 64'h8000_0003, 0, 64'h1122_3344_5566_7788, 64'h55,
            8'h00, 0, 0, 0, 0);
        txn(1, 0, 3'b000, 64'h8000_0000, 0, 64'h1122_3344_5566_7785,
            64'hFFFF_FFFF_FFFF_FF85, 8'h00, 0, 0, 0, 0);
        txn(1, 0, 3'b110, 64'h8000_0000, 0, 64'h0000_0000_8000_0000,
            64'h0000_0000_8000_0000, 8'h00, 0, 0, 0, 0);
        txn(1, 0, 3'b010, 64'h8000_0000, 0, 64'h0000_0000_8000_0000,
            64'hFFFF_FFFF_8000_0000, 8'h00, 0, 1, 0, 0);
        txn(1, 0, 3'b001, 64'h8000_0006, 0, 64'h8001_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_8001, 8'h00, 0, 0, 0, 0);
        txn(1, 0, 3'b101, 64'h8000_0002, 0, 64'h0000_0000_F00D_0000,
            64'h0000_0000_0000_F00D, 8'h00, 2, 0, 0, 0);
        txn(1, 0, 3'b011, 64'h8000_0008, 0, 64'h0123_4567_89AB_CDEF,
            64'h0123_4567_89AB_CDEF, 8'h00, 0, 3, 0, 0);

        // stores; the sw holds req_ready low for 5 cycles with a junk rsp_valid
        txn(0, 1, 3'b010, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 0, 0,
            8'hF0, 64'hDEAD_BEEF_0000_0000, 5, 2, 1);
        txn(0, 1, 3'b000, 64'h8000_0007, 64'h0000_0000_0000_00AB, 0, 0,
            8'h80, 64'hAB00_0000_0000_0000, 0, 0, 0);
        txn(0, 1, 3'b001, 64'h8000_0002, 64'h0000_0000_0000_1234, 0, 0,
            8'h0C, 64'h0000_0000_1234_0000, 0, 0, 0);
        txn(0, 1, 3'b011, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 0, 0,
            8'hFF, 64'h0123_4567_89AB_CDEF, 1, 1, 0);

        // rejected accesses
        bad_req(1, 0, 3'b011, 64'h8000_0004);
        bad_req(1, 0, 3'b001, 64'h8000_0001);
        bad_req(1, 0, 3'b110, 64'h8000_0002);
        bad_req(1, 0, 3'b111, 64'h8000_0000);
        bad_req(1, 1, 3'b000, 64'h8000_0000);
        bad_req(0, 1, 3'b100, 64'h8000_0000);

        // timeout: no req_ready; err arrives 16 cycles after entering REQ
        push_ev(1'b1, 1'b1, 64'd0);
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; func3 = 3'b010; addr = 64'h8000_0010;
        @(negedge clk);
        check("to_start_stall", stall, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("to_req_valid", req_valid, 1'b1);
            check("to_stall", stall, 1'b1);
            check("to_err_early", err, 1'b0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("to_done_req_valid", req_valid, 1'b0);
        check("to_done_stall", stall, 1'b0);

        // async reset while in RSP, with ex_valid still held by the pipeline
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_ren = 1'b1; func3 = 3'b010; addr = 64'h8000_0008;
        @(posedge clk); #1;
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        @(negedge clk);
        check("rsp_before_rst_stall", stall, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_req_valid", req_valid, 1'b0);
        check("rst_mid_ld_valid", ld_valid, 1'b0);
        check("rst_mid_err", err, 1'b0);
        check("rst_mid_ld_data", ld_data, 64'd0);
        idle_inputs();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_stall", stall, 1'b0);
        check("rst_rel_req_valid", req_valid, 1'b0);

        txn(1, 0, 3'b010, 64'h8000_0004, 0, 64'h89AB_CDEF_0000_0000,
            64'hFFFF_FFFF_89AB_CDEF, 8'h00, 0, 0, 0, 0);

        @(posedge clk); #1;
        @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
